// File: rtl/mesh_sink_pkg.sv
// Shared field layout, defaults and FSM encoding for the mesh terminal sink.
// Field offsets are counted down from the packet MSB so they hold for any PCK_SZ.
package mesh_sink_pkg;

  localparam int PCK_SZ_DEF = 41;

  localparam int NJ_MSB   = 0;
  localparam int NJ_W     = 8;
  localparam int ROW_MSB  = 8;
  localparam int ROW_W    = 4;
  localparam int COL_MSB  = 12;
  localparam int COL_W    = 4;
  localparam int MODE_BIT = 16;

  localparam logic [NJ_W-1:0] BROADCAST_DEF = 8'hFF;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } sink_state_e;

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mesh_sink_fifo.sv
// Synchronous FIFO for accepted packets; DEPTH must be a power of two (>= 2)
// so the pointers wrap naturally. Storage is not reset, only pointers/level.
module mesh_sink_fifo #(
  parameter  int DATA_W = 41,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int LVL_W  = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = lvl_q;
  assign rdata   = empty ? '0 : mem[rd_q];

  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q;
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/mesh_term_sink.sv
// Terminal-side receiver: pops router packets, filters by destination, buffers
// accepted ones for a valid/ready consumer. Statistics built only with MESH_SINK_STATS_EN.
module mesh_term_sink
  import mesh_sink_pkg::*;
#(
  parameter int              PCK_SZ    = PCK_SZ_DEF,
  parameter int              ROW_ID    = 1,
  parameter int              COL_ID    = 1,
  parameter int              DEPTH     = 4,
  parameter logic [NJ_W-1:0] BROADCAST = BROADCAST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pndng,
  input  logic [PCK_SZ-1:0]        data_out,
  output logic                     pop,
  output logic [PCK_SZ-1:0]        rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     misroute,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         rx_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam logic [ROW_W-1:0] ROW_L = ROW_W'(ROW_ID);
  localparam logic [COL_W-1:0] COL_L = COL_W'(COL_ID);

  sink_state_e       state_q, state_d;
  logic              pop_q, pop_d;
  logic              acc_q, acc_d;
  logic [PCK_SZ-1:0] pkt_q, pkt_d;

  logic [NJ_W-1:0]   nj;
  logic [ROW_W-1:0]  dst_row;
  logic [COL_W-1:0]  dst_col;
  logic              hit;
  logic              fifo_full;
  logic              fifo_empty;

  assign nj      = data_out[PCK_SZ-1-NJ_MSB  -: NJ_W];
  assign dst_row = data_out[PCK_SZ-1-ROW_MSB -: ROW_W];
  assign dst_col = data_out[PCK_SZ-1-COL_MSB -: COL_W];
  assign hit     = (nj == BROADCAST) || ((dst_row == ROW_L) && (dst_col == COL_L));

  // IDLE -> POP -> GAP: pop is registered, so the router sees exactly one
  // pulse per packet and gets a spare cycle to present the next one.
  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    acc_d   = 1'b0;
    pkt_d   = pkt_q;
    case (state_q)
      IDLE: begin
        if (pndng && !fifo_full) begin
          state_d = POP;
          pop_d   = 1'b1;
        end
      end
      POP: begin
        state_d = GAP;
        pkt_d   = data_out;
        acc_d   = hit;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
    if (reset) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      acc_q   <= acc_d;
    end
  end

  assign pop = pop_q;

  // The captured packet is pushed during GAP; the full check taken in IDLE
  // still holds because the level can only drop in between.
  mesh_sink_fifo #(
    .DATA_W (PCK_SZ),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (acc_q),
    .wdata (pkt_q),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rx_valid = !fifo_empty;

`ifdef MESH_SINK_STATS_EN
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    miss_d    = (state_q == POP) && !hit;
    rx_cnt_d  = acc_q  ? sat_inc(rx_cnt_q)  : rx_cnt_q;
    err_cnt_d = miss_q ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_q    <= 1'b0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      miss_q    <= miss_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign misroute  = miss_q;
  assign rx_count  = rx_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign misroute  = 1'b0;
  assign rx_count  = '0;
  assign err_count = '0;
`endif

endmodule
